// File: rtl/prbs_frame_ctrl.sv
// PRBS frame sequencer: paces PRBS-23 nibbles into preamble/payload/gap frames with a valid/ready output.
// Optional preamble phase is compiled in with `define PRBS_FRAME_PREAMBLE_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start, output register may still be draining
// PREAMBLE | loading alternating F/0 preamble symbols (macro builds only)
// PAYLOAD  | loading generator nibbles from the 2-entry FIFO
// GAP      | counting idle symbol ticks, then restart or return to IDLE
module prbs_frame_ctrl #(
    parameter int PAYLOAD_LEN  = 256,
    parameter int PREAMBLE_LEN = 16,
    parameter int GAP_LEN      = 8,
    parameter int DIV_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic [DIV_W-1:0] sym_div,
    output logic             gen_en,
    input  logic [3:0]       gen_bits,
    input  logic             gen_valid,
    output logic [3:0]       sym_bits,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    localparam int CMAX = (PREAMBLE_LEN > PAYLOAD_LEN) ? PREAMBLE_LEN : PAYLOAD_LEN;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int GW   = $clog2(GAP_LEN + 2);

    localparam logic [CW-1:0] PAY_LAST = CW'(PAYLOAD_LEN - 1);
    localparam logic [CW-1:0] PAY_N    = CW'(PAYLOAD_LEN);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

`ifdef PRBS_FRAME_PREAMBLE_EN
    localparam state_t FIRST_ST = PREAMBLE;
`else
    localparam state_t FIRST_ST = PAYLOAD;
`endif

    state_t           state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick_pend;
    logic [CW-1:0]    sym_cnt;
    logic [CW-1:0]    req_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             stop_pend;
    logic             in_flight;

    logic [3:0]       fifo_mem [2];
    logic             fifo_wp;
    logic             fifo_rp;
    logic [1:0]       fifo_cnt;

    logic             tick;
    logic             ptick;
    logic             in_pre;
    logic             in_pay;
    logic             sym_avail;
    logic             out_free;
    logic             load;
    logic             pop;
    logic             hs;
    logic             last_sym;
    logic             gap_done;
    logic             go_again;
    logic [3:0]       pre_sym;
    logic [3:0]       load_bits;

`ifdef PRBS_FRAME_PREAMBLE_EN
    assign in_pre = (state == PREAMBLE);
`else
    assign in_pre = 1'b0;
`endif
    assign in_pay = (state == PAYLOAD);

    // Down-counter reloads from the sampled divider; terminal count is the symbol tick.
    assign tick      = (state != IDLE) && (tick_cnt == '0);
    assign ptick     = tick || tick_pend;
    assign out_free  = !sym_valid || sym_ready;
    assign sym_avail = in_pre || (in_pay && (fifo_cnt != 2'd0));
    assign load      = ptick && sym_avail && out_free;
    assign pop       = load && in_pay;
    assign hs        = sym_valid && sym_ready;
    assign last_sym  = (sym_cnt == (in_pre ? PRE_LAST : PAY_LAST));
    assign gap_done  = (GAP_LEN == 0) || (tick && (gap_cnt == GAP_LAST));
    assign go_again  = continuous && !stop_pend && !stop;
    assign pre_sym   = sym_cnt[0] ? 4'h0 : 4'hF;
    assign load_bits = in_pre ? pre_sym : fifo_mem[fifo_rp];

    // Requests are bounded by FIFO space including the one nibble still in the generator.
    assign gen_en = (in_pre || in_pay)
                 && ((fifo_cnt + {1'b0, in_flight}) < 2'd2)
                 && (req_cnt != PAY_N);

    assign busy = (state != IDLE) || sym_valid;

    always_ff @(posedge clk) begin
        if (gen_valid) begin
            fifo_mem[fifo_wp] <= gen_bits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_q     <= '0;
            tick_cnt  <= '0;
            tick_pend <= 1'b0;
            sym_cnt   <= '0;
            req_cnt   <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
            in_flight <= 1'b0;
            fifo_wp   <= 1'b0;
            fifo_rp   <= 1'b0;
            fifo_cnt  <= 2'd0;
            sym_bits  <= 4'h0;
            sym_valid <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            in_flight <= gen_en;

            if (gen_valid) begin
                fifo_wp <= !fifo_wp;
            end
            if (pop) begin
                fifo_rp <= !fifo_rp;
            end
            fifo_cnt <= fifo_cnt + 2'(gen_valid) - 2'(pop);

            if (state == IDLE) begin
                if (start) begin
                    div_q    <= sym_div;
                    tick_cnt <= sym_div;
                end
            end else begin
                tick_cnt <= (tick_cnt == '0) ? div_q : tick_cnt - DIV_W'(1);
            end

            // At most one tick is remembered; gap ticks are consumed by the gap counter.
            if (in_pre || in_pay) begin
                tick_pend <= ptick && !load;
            end else begin
                tick_pend <= 1'b0;
            end

            if (gen_en) begin
                req_cnt <= req_cnt + CW'(1);
            end

            if (load) begin
                sym_valid <= 1'b1;
                sym_bits  <= load_bits;
                sof       <= (state == FIRST_ST) && (sym_cnt == '0);
                eof       <= in_pay && last_sym;
            end else if (hs) begin
                sym_valid <= 1'b0;
                sof       <= 1'b0;
                eof       <= 1'b0;
            end

            if (hs && eof) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (state == IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop) begin
                stop_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FIRST_ST;
                        sym_cnt <= '0;
                        req_cnt <= '0;
                    end
                end
`ifdef PRBS_FRAME_PREAMBLE_EN
                PREAMBLE: begin
                    if (load) begin
                        if (last_sym) begin
                            state   <= PAYLOAD;
                            sym_cnt <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + CW'(1);
                        end
                    end
                end
`endif
                PAYLOAD: begin
                    if (load) begin
                        if (last_sym) begin
                            state   <= GAP;
                            sym_cnt <= '0;
                            gap_cnt <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + CW'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (go_again) begin
                            state   <= FIRST_ST;
                            sym_cnt <= '0;
                            req_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (tick) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The request bound keeps FIFO occupancy plus in-flight at two or less.
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(gen_valid && (fifo_cnt == 2'd2)));

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// Directed bench for prbs_frame_ctrl with a PRBS-23 generator model and a symbol scoreboard.
module tb_prbs_frame_ctrl;

    localparam int PAY = 8;
    localparam int PRE = 4;
    localparam int GAP = 2;
`ifdef PRBS_FRAME_PREAMBLE_EN
    localparam int NPRE = PRE;
    localparam int LAT0 = 1;
`else
    localparam int NPRE = 0;
    localparam int LAT0 = 3;
`endif
    localparam int FRAME = NPRE + PAY;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [7:0]  sym_div;
    logic        gen_en;
    logic [3:0]  gen_bits;
    logic        gen_valid;
    logic [3:0]  sym_bits;
    logic        sym_valid;
    logic        sym_ready;
    logic        sof;
    logic        eof;
    logic        busy;
    logic [15:0] frame_cnt;

    prbs_frame_ctrl #(
        .PAYLOAD_LEN (PAY),
        .PREAMBLE_LEN(PRE),
        .GAP_LEN     (GAP),
        .DIV_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .continuous(continuous),
        .sym_div   (sym_div),
        .gen_en    (gen_en),
        .gen_bits  (gen_bits),
        .gen_valid (gen_valid),
        .sym_bits  (sym_bits),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sof       (sof),
        .eof       (eof),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Generator model: x^23+x^18+1 from all-ones, one nibble per gen_en, valid one cycle later.
    logic [22:0] lfsr = '1;
    logic        gen_pend = 1'b0;
    logic [3:0]  exp_q[$];
    int          gen_cnt = 0;

    always @(negedge clk) begin
        logic [3:0] nib;
        logic       nb;
        gen_valid = gen_pend;
        if (gen_pend) begin
            nib = 4'h0;
            for (int i = 0; i < 4; i++) begin
                nb   = lfsr[22] ^ lfsr[17];
                lfsr = {lfsr[21:0], nb};
                nib  = {nib[2:0], nb};
            end
            gen_bits = nib;
            exp_q.push_back(nib);
        end
        gen_pend = gen_en;
        if (gen_en) gen_cnt++;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int idx = 0;
    int hs_cnt = 0;
    int hs_times[$];

    // Every valid cycle is checked against the next expected symbol, so stalls must hold stable.
    always @(negedge clk) begin
        logic [3:0] eb;
        logic       have;
        if (!rst_n) begin
            idx = 0;
        end else if (sym_valid) begin
            have = 1'b1;
            if (idx < NPRE) begin
                eb = (idx % 2 == 0) ? 4'hF : 4'h0;
            end else begin
                have = (exp_q.size() != 0);
                check("payload_avail", {31'd0, have}, 32'd1);
                eb = have ? exp_q[0] : 4'h0;
            end
            check("symbol", {26'd0, sof, eof, sym_bits},
                  {26'd0, (idx == 0), (idx == FRAME - 1), eb});
            if (sym_ready) begin
                if (idx >= NPRE && have) void'(exp_q.pop_front());
                idx = (idx + 1) % FRAME;
                hs_cnt++;
                hs_times.push_back(cyc);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_hs(input int target, input string tag);
        int k = 0;
        while (hs_cnt < target && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, {31'd0, (hs_cnt >= target)}, 32'd1);
    endtask

    task automatic do_start(output int lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!sym_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int f0, g0, h0, lat;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        sym_div = 8'd0; sym_ready = 1'b1; gen_valid = 1'b0; gen_bits = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {23'd0, gen_en, sym_valid, sym_bits, sof, eof, busy}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame, sym_div=0
        f0 = frame_cnt; g0 = gen_cnt; h0 = hs_cnt;
        do_start(lat);
        check("latency_div0", lat, LAT0);
        wait_idle("single_idle");
        check("single_frame_cnt", {16'd0, frame_cnt}, f0 + 1);
        check("single_hs", hs_cnt - h0, FRAME);
        check("single_gen", gen_cnt - g0, PAY);
        check("single_fifo_empty", exp_q.size(), 0);

        // Three continuous frames, stop during the third
        continuous = 1'b1;
        f0 = frame_cnt; g0 = gen_cnt; h0 = hs_cnt;
        do_start(lat);
        wait_hs(h0 + 2 * FRAME + 1, "cont_reach_f3");
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_idle("cont_idle");
        continuous = 1'b0;
        check("cont_frame_cnt", {16'd0, frame_cnt}, f0 + 3);
        check("cont_gen", gen_cnt - g0, 3 * PAY);
        check("cont_hs", hs_cnt - h0, 3 * FRAME);

        // Symbol pacing with sym_div=3
        sym_div = 8'd3;
        hs_times.delete();
        f0 = frame_cnt;
        do_start(lat);
        check("latency_div3", lat, 4);
        wait_idle("div3_idle");
        check("div3_count", hs_times.size(), FRAME);
        for (int i = 1; i < hs_times.size(); i++) begin
            check("div3_period", hs_times[i] - hs_times[i-1], 4);
        end
        check("div3_frame_cnt", {16'd0, frame_cnt}, f0 + 1);
        sym_div = 8'd0;

        // Backpressure for 10 cycles mid-payload
        f0 = frame_cnt; g0 = gen_cnt; h0 = hs_cnt;
        do_start(lat);
        wait_hs(h0 + NPRE + 3, "stall_reach");
        sym_ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("stall_valid", {31'd0, sym_valid}, 32'd1);
        check("stall_gen", gen_cnt - g0, 6);
        sym_ready = 1'b1;
        wait_idle("stall_idle");
        check("stall_hs", hs_cnt - h0, FRAME);
        check("stall_gen_total", gen_cnt - g0, PAY);
        check("stall_frame_cnt", {16'd0, frame_cnt}, f0 + 1);

        // start ignored mid-frame, stop ends continuous run after this frame
        continuous = 1'b1;
        f0 = frame_cnt; g0 = gen_cnt; h0 = hs_cnt;
        do_start(lat);
        wait_hs(h0 + NPRE + 1, "stop_reach");
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        wait_idle("stop_idle");
        continuous = 1'b0;
        check("stop_frame_cnt", {16'd0, frame_cnt}, f0 + 1);
        check("stop_hs", hs_cnt - h0, FRAME);
        check("stop_gen", gen_cnt - g0, PAY);

        // Asynchronous reset mid-payload, then a clean frame
        h0 = hs_cnt;
        do_start(lat);
        wait_hs(h0 + NPRE + 2, "rst_reach");
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {23'd0, gen_en, sym_valid, sym_bits, sof, eof, busy}, 32'd0);
        check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        g0 = gen_cnt; h0 = hs_cnt;
        do_start(lat);
        check("post_rst_latency", lat, LAT0);
        wait_idle("post_rst_idle");
        check("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        check("post_rst_hs", hs_cnt - h0, FRAME);
        check("post_rst_gen", gen_cnt - g0, PAY);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
